controle_passos: RTL and testbench

Step sequencer for the toy-automation controller. Runs the toy through a fixed sequence of numbered steps, either timed automatically or advanced by hand, with start/pause/stop control. Its 3-bit step code drives the seven-segment step decoder directly: `passo[2]` is x (MSB), `passo[1]` is y, `passo[0]` is z (LSB). It is the only writer of the displayed step.

---
 rtl/controle_passos_pkg.sv | 17 +
 rtl/gerador_tick.sv | 34 +++
 rtl/controle_passos.sv | 156 +++++++++++++++
 tb/tb_controle_passos.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_passos_pkg.sv
// Shared types and constants for the step sequencer.
package controle_passos_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        PARADO  = 2'd0,
        RODANDO = 2'd1,
        PAUSADO = 2'd2
    } estado_t;

    // Width of the step code driving the seven-segment step decoder (x,y,z)
    localparam int PASSO_W    = 3;

    // Largest number of steps the 3-bit step code can represent
    localparam int MAX_PASSOS = 8;

endpackage

// File: rtl/gerador_tick.sv
// Timing prescaler: counts 0..TICK_DIV-1 while enabled and flags the last count.
module gerador_tick #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] ULTIMO = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Prescaler counter: clear has priority, otherwise count and wrap while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == ULTIMO) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tick = (cnt == ULTIMO);

endmodule

// File: rtl/controle_passos.sv
// Step sequencer: walks the toy through N_PASSOS numbered steps, timed or manual,
// with start/pause/stop control. All outputs come straight from flops.
module controle_passos
    import controle_passos_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int DWELL_TICKS = 3,
    parameter int N_PASSOS    = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iniciar,
    input  logic               pausar,
    input  logic               parar,
    input  logic               manual,
    input  logic               avancar,
    output logic [PASSO_W-1:0] passo,
    output logic               ativo,
    output logic               pausado,
    output logic               fim
);

    localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [DW-1:0]      DWELL_ULT = DW'(DWELL_TICKS - 1);
    localparam logic [PASSO_W-1:0] PASSO_ULT = PASSO_W'(N_PASSOS - 1);

    estado_t            estado;
    estado_t            estado_prox;
    logic [DW-1:0]      dwell;
    logic [DW-1:0]      dwell_prox;
    logic [PASSO_W-1:0] passo_prox;
    logic               fim_prox;
    logic               ativo_prox;
    logic               pausado_prox;
    logic               avanca;
    logic               pre_en;
    logic               pre_clr;
    logic               tick;

    gerador_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_gerador_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (pre_clr),
        .tick  (tick)
    );

    // State register together with the step, dwell and output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado  <= PARADO;
            passo   <= '0;
            dwell   <= '0;
            fim     <= 1'b0;
            ativo   <= 1'b0;
            pausado <= 1'b0;
        end else begin
            estado  <= estado_prox;
            passo   <= passo_prox;
            dwell   <= dwell_prox;
            fim     <= fim_prox;
            ativo   <= ativo_prox;
            pausado <= pausado_prox;
        end
    end

    // Next-state logic: request priority parar > pausar > iniciar > advance
    always_comb begin
        estado_prox = estado;
        passo_prox  = passo;
        dwell_prox  = dwell;
        fim_prox    = 1'b0;
        pre_en      = 1'b0;
        pre_clr     = 1'b0;
        avanca      = 1'b0;

        unique case (estado)
            PARADO: begin
                if (iniciar && !parar) begin
                    estado_prox = RODANDO;
                    passo_prox  = '0;
                    dwell_prox  = '0;
                    pre_clr     = 1'b1;
                end
            end

            RODANDO: begin
                if (parar) begin
                    estado_prox = PARADO;
                    passo_prox  = '0;
                    dwell_prox  = '0;
                    pre_clr     = 1'b1;
                end else if (pausar) begin
                    estado_prox = PAUSADO;
                    // A tick landing on the pause edge is held in the prescaler
                    // and consumed after resume instead of being lost.
                    pre_en      = !manual && !tick;
                end else if (manual) begin
                    if (avancar) begin
                        avanca     = 1'b1;
                        dwell_prox = '0;
                    end
                end else begin
                    pre_en = 1'b1;
                    if (tick) begin
                        if (dwell < DWELL_ULT) begin
                            dwell_prox = dwell + 1'b1;
                        end else begin
                            dwell_prox = '0;
                            avanca     = 1'b1;
                        end
                    end
                end

                if (avanca) begin
                    if (passo < PASSO_ULT) begin
                        passo_prox = passo + 1'b1;
                    end else begin
                        estado_prox = PARADO;
                        passo_prox  = '0;
                        dwell_prox  = '0;
                        fim_prox    = 1'b1;
                        pre_clr     = 1'b1;
                    end
                end
            end

            PAUSADO: begin
                if (parar) begin
                    estado_prox = PARADO;
                    passo_prox  = '0;
                    dwell_prox  = '0;
                    pre_clr     = 1'b1;
                end else if (iniciar) begin
                    estado_prox = RODANDO;
                end
            end

            default: begin
                estado_prox = PARADO;
                passo_prox  = '0;
                dwell_prox  = '0;
                pre_clr     = 1'b1;
            end
        endcase
    end

    // Output decode from the next state, so ativo/pausado are registered
    always_comb begin
        ativo_prox   = (estado_prox != PARADO);
        pausado_prox = (estado_prox == PAUSADO);
    end

endmodule

// File: tb/tb_controle_passos.sv
// Self-checking bench for controle_passos (TICK_DIV=4, DWELL_TICKS=2, N_PASSOS=6).
// Expected outputs {passo, ativo, pausado, fim} are queued as stimulus is driven
// and compared once the DUT has responded.
module tb_controle_passos;

    localparam int TD    = 4;
    localparam int DWT   = 2;
    localparam int NP    = 6;
    localparam int CICLO = TD * DWT;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       iniciar = 1'b0;
    logic       pausar  = 1'b0;
    logic       parar   = 1'b0;
    logic       manual  = 1'b0;
    logic       avancar = 1'b0;
    logic [2:0] passo;
    logic       ativo;
    logic       pausado;
    logic       fim;

    int n_checks = 0;
    int n_pass   = 0;
    logic [5:0] fila[$];

    controle_passos #(
        .TICK_DIV    (TD),
        .DWELL_TICKS (DWT),
        .N_PASSOS    (NP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .iniciar (iniciar),
        .pausar  (pausar),
        .parar   (parar),
        .manual  (manual),
        .avancar (avancar),
        .passo   (passo),
        .ativo   (ativo),
        .pausado (pausado),
        .fim     (fim)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] pack(input int p, input logic a, input logic pz, input logic f);
        logic [2:0] pp;
        pp = 3'(p);
        return {pp, a, pz, f};
    endfunction

    // Automatic-run schedule, e = running cycles since the start edge
    function automatic logic [5:0] esperado_auto(input int e);
        if (e < NP * CICLO)       return pack(e / CICLO, 1'b1, 1'b0, 1'b0);
        else if (e == NP * CICLO) return pack(0, 1'b0, 1'b0, 1'b1);
        else                      return pack(0, 1'b0, 1'b0, 1'b0);
    endfunction

    // One clock edge with the given pulses, returns at the following negedge
    task automatic borda(input logic ini, input logic pau, input logic par, input logic ava);
        iniciar = ini;
        pausar  = pau;
        parar   = par;
        avancar = ava;
        @(posedge clk);
        @(negedge clk);
        iniciar = 1'b0;
        pausar  = 1'b0;
        parar   = 1'b0;
        avancar = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] obs, esp;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst_n = 1'b1;
            borda(i == 1, 1'b0, 1'b0, 1'b0);
            fila.push_back(pack(0, 1'b0, 1'b0, 1'b0));
            obs = {passo, ativo, pausado, fim};
            esp = fila.pop_front();
            n_checks++;
            if (obs !== esp) $display("FAIL reset i=%0d {passo,ativo,pausado,fim} got %b want %b", i, obs, esp);
            else n_pass++;
        end
    endtask

    task automatic test_auto();
        logic [5:0] obs, esp;
        manual = 1'b0;
        for (int t = 0; t <= 52; t++) begin
            borda(t == 0, 1'b0, 1'b0, 1'b0);
            fila.push_back(esperado_auto(t));
            obs = {passo, ativo, pausado, fim};
            esp = fila.pop_front();
            n_checks++;
            if (obs !== esp) $display("FAIL auto t=%0d {passo,ativo,pausado,fim} got %b want %b", t, obs, esp);
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        logic [5:0] obs, esp;
        manual = 1'b0;
        for (int t = 0; t <= 62; t++) begin
            borda(t == 0 || t == 15, t == 5, 1'b0, 1'b0);
            if (t < 5)       fila.push_back(esperado_auto(t));
            else if (t < 15) fila.push_back(pack(0, 1'b1, 1'b1, 1'b0));
            else             fila.push_back(esperado_auto(t - 10));
            obs = {passo, ativo, pausado, fim};
            esp = fila.pop_front();
            n_checks++;
            if (obs !== esp) $display("FAIL pause t=%0d {passo,ativo,pausado,fim} got %b want %b", t, obs, esp);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        logic [5:0] obs, esp;
        manual = 1'b0;
        for (int t = 0; t <= 60; t++) begin
            borda(t == 0, 1'b0, t == 20, 1'b0);
            if (t < 20) fila.push_back(esperado_auto(t));
            else        fila.push_back(pack(0, 1'b0, 1'b0, 1'b0));
            obs = {passo, ativo, pausado, fim};
            esp = fila.pop_front();
            n_checks++;
            if (obs !== esp) $display("FAIL abort t=%0d {passo,ativo,pausado,fim} got %b want %b", t, obs, esp);
            else n_pass++;
        end
    endtask

    task automatic test_manual();
        logic [5:0] obs, esp;
        manual = 1'b1;
        // six avancar pulses at edges 3,6,...,18
        for (int t = 0; t <= 21; t++) begin
            borda(t == 0, 1'b0, 1'b0, (t > 0) && (t % 3 == 0) && (t <= 18));
            if (t < 18)       fila.push_back(pack(t / 3, 1'b1, 1'b0, 1'b0));
            else if (t == 18) fila.push_back(pack(0, 1'b0, 1'b0, 1'b1));
            else              fila.push_back(pack(0, 1'b0, 1'b0, 1'b0));
            obs = {passo, ativo, pausado, fim};
            esp = fila.pop_front();
            n_checks++;
            if (obs !== esp) $display("FAIL manual t=%0d {passo,ativo,pausado,fim} got %b want %b", t, obs, esp);
            else n_pass++;
        end
        // two pulses, then 100 idle cycles in manual mode, then abort
        for (int s = 0; s <= 104; s++) begin
            borda(s == 0, 1'b0, s == 103, s == 1 || s == 2);
            if (s >= 103)    fila.push_back(pack(0, 1'b0, 1'b0, 1'b0));
            else if (s >= 2) fila.push_back(pack(2, 1'b1, 1'b0, 1'b0));
            else             fila.push_back(pack(s, 1'b1, 1'b0, 1'b0));
            obs = {passo, ativo, pausado, fim};
            esp = fila.pop_front();
            n_checks++;
            if (obs !== esp) $display("FAIL manual_hold s=%0d {passo,ativo,pausado,fim} got %b want %b", s, obs, esp);
            else n_pass++;
        end
        manual = 1'b0;
    endtask

    task automatic test_simult();
        logic [5:0] obs, esp;
        logic [3:0] stim [0:10];  // {iniciar, pausar, parar, avancar}
        logic [5:0] want [0:10];
        stim = '{4'b1010, 4'b0000, 4'b1000, 4'b0001, 4'b0101, 4'b0001,
                 4'b0000, 4'b1000, 4'b0001, 4'b1110, 4'b0000};
        want = '{6'b000_000, 6'b000_000, 6'b000_100, 6'b001_100, 6'b001_110, 6'b001_110,
                 6'b001_110, 6'b001_100, 6'b010_100, 6'b000_000, 6'b000_000};
        manual = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            borda(stim[c][3], stim[c][2], stim[c][1], stim[c][0]);
            fila.push_back(want[c]);
            obs = {passo, ativo, pausado, fim};
            esp = fila.pop_front();
            n_checks++;
            if (obs !== esp) $display("FAIL simult c=%0d {passo,ativo,pausado,fim} got %b want %b", c, obs, esp);
            else n_pass++;
        end
        manual = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [5:0] obs, esp;
        manual = 1'b0;
        for (int t = 0; t <= 26; t++) begin
            borda(t == 0, 1'b0, 1'b0, 1'b0);
            fila.push_back(esperado_auto(t));
            obs = {passo, ativo, pausado, fim};
            esp = fila.pop_front();
            n_checks++;
            if (obs !== esp) $display("FAIL areset_run t=%0d {passo,ativo,pausado,fim} got %b want %b", t, obs, esp);
            else n_pass++;
        end
        // assert reset between edges and look before the next rising edge
        #2 rst_n = 1'b0;
        fila.push_back(pack(0, 1'b0, 1'b0, 1'b0));
        #1;
        obs = {passo, ativo, pausado, fim};
        esp = fila.pop_front();
        n_checks++;
        if (obs !== esp) $display("FAIL areset_async {passo,ativo,pausado,fim} got %b want %b", obs, esp);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            borda(1'b0, 1'b0, 1'b0, 1'b0);
            fila.push_back(pack(0, 1'b0, 1'b0, 1'b0));
            obs = {passo, ativo, pausado, fim};
            esp = fila.pop_front();
            n_checks++;
            if (obs !== esp) $display("FAIL areset_idle i=%0d {passo,ativo,pausado,fim} got %b want %b", i, obs, esp);
            else n_pass++;
        end
        for (int t = 0; t <= 10; t++) begin
            borda(t == 0, 1'b0, t == 10, 1'b0);
            if (t < 10) fila.push_back(esperado_auto(t));
            else        fila.push_back(pack(0, 1'b0, 1'b0, 1'b0));
            obs = {passo, ativo, pausado, fim};
            esp = fila.pop_front();
            n_checks++;
            if (obs !== esp) $display("FAIL areset_restart t=%0d {passo,ativo,pausado,fim} got %b want %b", t, obs, esp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_auto();
        test_pause();
        test_abort();
        test_manual();
        test_simult();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d passed of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
